front_panel_sequencer: RTL and testbench
========================================

# front_panel_sequencer

Command sequencer for the Altair front-panel Examine, Examine Next, Deposit and Deposit Next switches. It sits between the debounced panel switches and the CPU data-in / memory-write path. Switch edges are accepted only while the CPU is stopped, and one operation runs at a time. The block jams opcode bytes onto the CPU data bus in step with CPU read cycles, and it issues single-cycle memory write strobes for deposits.

## Interface
- TIMEOUT_CYCLES, 1024: maximum clocks between consecutive CPU read completions before the operation is aborted.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sw_examine  in  1  debounced panel switch, level.
- sw_examine_next  in  1  debounced panel switch, level.
- sw_deposit  in  1  debounced panel switch, level.
- sw_deposit_next  in  1  debounced panel switch, level.
- stop_mode  in  1  1 = CPU stopped; commands are accepted only while this is 1.
- cpu_rd  in  1  CPU read strobe; a falling edge marks a completed read.
- addr_sw  in  16  address switches.
- data_sw  in  8  data switches.
- jam_en  out  1  when 1, jam_data overrides CPU data-in.
- jam_data  out  8  byte presented to the CPU.
- wr_en  out  1  single-cycle memory write strobe.
- wr_data  out  8  write data.
- busy  out  1  operation in progress.
- done  out  1  single-cycle pulse on normal completion.
- timeout  out  1  single-cycle pulse on abort by the watchdog.

## Operation
- Command detection
  - A command is a rising edge on a sw_* input, using the previous-cycle sample.
  - It is accepted only in IDLE with stop_mode=1.
  - Edges seen while busy or while stop_mode=0 are discarded, not queued.
- Priority when edges coincide: examine > examine_next > deposit_next > deposit. Lower-priority edges are dropped.
- On accept, addr_sw and data_sw are captured into internal registers. Later switch changes do not affect the running operation.
- States:
  - IDLE
  - EX_JMP: jam 0xC3.
  - EX_LO: jam addr[7:0].
  - EX_HI: jam addr[15:8].
  - NXT_NOP: jam 0x00.
  - DEP_WR
- Read-driven transitions advance on a cpu_rd falling edge:
  - EX_JMP -> EX_LO
  - EX_LO -> EX_HI
  - EX_HI -> IDLE, with done.
  - NXT_NOP -> IDLE with done (Examine Next), or -> DEP_WR (Deposit Next).
- Deposit goes directly IDLE -> DEP_WR.
- DEP_WR lasts exactly one cycle:
  - wr_en=1 and wr_data = captured data.
  - The next state is IDLE, with done.
- jam_en=1 in every state from EX_JMP through NXT_NOP; 0 in IDLE and DEP_WR.
- busy=1 whenever the state is not IDLE.
- Watchdog: a counter runs in every jam state.
  - It clears on entry to a state and on each cpu_rd falling edge.
  - Reaching TIMEOUT_CYCLES forces IDLE and pulses timeout. done is not pulsed.
- If stop_mode falls while busy, the block goes to IDLE on the next clock. Neither done nor timeout is pulsed.
- reset (sync): state IDLE, edge registers cleared.
  - Outputs after reset: jam_en=0, jam_data=0x00, wr_en=0, wr_data=0x00, busy=0, done=0, timeout=0.
  - Reset overrides every other event in the same cycle.

## Timing
- Command edge in cycle N: the state changes at the end of N. busy, jam_en and jam_data are valid in cycle N+1.
- jam_data is registered and stable for the whole CPU read. It changes only in the cycle after the cpu_rd falling edge.
- The falling-edge detect has 1 cycle of latency. The jam state updates 1 cycle after cpu_rd returns low.
- Examine consumes exactly 3 CPU reads. Examine Next consumes 1. Deposit consumes 0. Deposit Next consumes 1 read, then DEP_WR in the following cycle.
- done and wr_en are coincident for deposit operations.
- The watchdog counter is width clog2(TIMEOUT_CYCLES+1). timeout asserts in the cycle after the count reaches TIMEOUT_CYCLES.
- A cpu_rd falling edge in the same cycle as a stop_mode drop: the abort wins.

## Structure
- Shared package altair_panel_pkg holds:
  - OP_JMP=8'hC3 and OP_NOP=8'h00.
  - The state enum.
  - The command priority encoding.
- Sub-module panel_edge_detect holds the registered rising/falling edge detectors. It is instantiated for the four switches (rising) and cpu_rd (falling).

## Test plan
- Examine, addr_sw=0x1234, stop_mode=1, three rd pulses -> jam_data 0xC3, 0x34, 0x12 on successive reads; jam_en=0 and done pulse after the third.
- Examine Next, one rd pulse -> jam_data 0x00 during the read, then done; no wr_en.
- Deposit Next, data_sw=0xA5 -> NOP jammed for one read, then a 1-cycle wr_en with wr_data=0xA5 coincident with done.
- sw_examine and sw_deposit rising in the same cycle -> Examine runs and no wr_en is ever issued; a deposit edge while busy is also ignored.
- Examine started with no rd activity, TIMEOUT_CYCLES=16 -> timeout pulse 17 cycles after state entry, jam_en=0, no done.
- Reset asserted in EX_LO, and separately stop_mode dropped in EX_HI -> IDLE next cycle with every output at its reset value and no done.

Source files
------------

// File: rtl/altair_panel_pkg.sv
// Shared definitions for the Altair front-panel command sequencer:
// jammed opcodes, sequencer states and switch-command priority.
package altair_panel_pkg;

  localparam logic [7:0] OP_JMP = 8'hC3;
  localparam logic [7:0] OP_NOP = 8'h00;

  localparam int unsigned SW_W    = 4;
  localparam int unsigned SW_EX   = 0;
  localparam int unsigned SW_EXN  = 1;
  localparam int unsigned SW_DEP  = 2;
  localparam int unsigned SW_DEPN = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EX_JMP,
    ST_EX_LO,
    ST_EX_HI,
    ST_NXT_NOP,
    ST_DEP_WR
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_EXAMINE,
    CMD_EXAMINE_NEXT,
    CMD_DEPOSIT_NEXT,
    CMD_DEPOSIT
  } cmd_e;

  // Coincident edges: examine > examine_next > deposit_next > deposit
  function automatic cmd_e encode_cmd(input logic [SW_W-1:0] rise);
    if (rise[SW_EX])        return CMD_EXAMINE;
    else if (rise[SW_EXN])  return CMD_EXAMINE_NEXT;
    else if (rise[SW_DEPN]) return CMD_DEPOSIT_NEXT;
    else if (rise[SW_DEP])  return CMD_DEPOSIT;
    else                    return CMD_NONE;
  endfunction

  function automatic logic is_jam_state(input state_e s);
    return (s == ST_EX_JMP) || (s == ST_EX_LO) || (s == ST_EX_HI) || (s == ST_NXT_NOP);
  endfunction

endpackage

// File: rtl/panel_edge_detect.sv
// Edge detector against the previous-cycle sample; the edge is valid in the
// same cycle the new level is presented.
module panel_edge_detect
  import altair_panel_pkg::*;
#(
  parameter int unsigned W      = 1,
  parameter bit          RISING = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] edge_c_o
);

  logic [W-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= '0;
    else       prev_q <= d_i;
  end

  assign edge_c_o = RISING ? (d_i & ~prev_q) : (~d_i & prev_q);

endmodule

// File: rtl/front_panel_sequencer.sv
// Front-panel Examine/Deposit sequencer: jams JMP/NOP opcodes onto the CPU
// data bus in step with CPU reads and issues memory write strobes.
module front_panel_sequencer
  import altair_panel_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sw_examine,
  input  logic        sw_examine_next,
  input  logic        sw_deposit,
  input  logic        sw_deposit_next,
  input  logic        stop_mode,
  input  logic        cpu_rd,
  input  logic [15:0] addr_sw,
  input  logic [7:0]  data_sw,
  output logic        jam_en,
  output logic [7:0]  jam_data,
  output logic        wr_en,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done,
  output logic        timeout
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [SW_W-1:0] sw_rise_c;
  logic            rd_fall_c;

  panel_edge_detect #(.W(SW_W), .RISING(1'b1)) u_sw_edge (
    .clk      (clk),
    .reset    (reset),
    .d_i      ({sw_deposit_next, sw_deposit, sw_examine_next, sw_examine}),
    .edge_c_o (sw_rise_c)
  );

  panel_edge_detect #(.W(1), .RISING(1'b0)) u_rd_edge (
    .clk      (clk),
    .reset    (reset),
    .d_i      (cpu_rd),
    .edge_c_o (rd_fall_c)
  );

  state_e          state_q, state_d;
  cmd_e            cmd_c;
  logic            accept_c;
  logic            done_d, timeout_d;
  logic            is_dep_q, is_dep_d;
  logic [15:0]     addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            jam_en_q, jam_en_d;
  logic [7:0]      jam_data_q, jam_data_d;
  logic            wr_en_q, wr_en_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            busy_q, busy_d;
  logic            done_q, timeout_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state; a stop_mode drop aborts silently and beats any read edge
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    accept_c  = 1'b0;
    cmd_c     = encode_cmd(sw_rise_c);
    if (state_q != ST_IDLE && !stop_mode) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (stop_mode && cmd_c != CMD_NONE) begin
            accept_c = 1'b1;
            case (cmd_c)
              CMD_EXAMINE: state_d = ST_EX_JMP;
              CMD_DEPOSIT: state_d = ST_DEP_WR;
              default:     state_d = ST_NXT_NOP;
            endcase
          end
        end
        ST_EX_JMP, ST_EX_LO, ST_EX_HI, ST_NXT_NOP: begin
          if (wd_q >= WD_W'(TIMEOUT_CYCLES)) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
          end else if (rd_fall_c) begin
            case (state_q)
              ST_EX_JMP: state_d = ST_EX_LO;
              ST_EX_LO:  state_d = ST_EX_HI;
              ST_EX_HI: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
              ST_NXT_NOP: begin
                state_d = is_dep_q ? ST_DEP_WR : ST_IDLE;
                done_d  = !is_dep_q;
              end
              default: state_d = ST_IDLE;
            endcase
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Deposit completion is reported alongside the write strobe
    if (state_d == ST_DEP_WR) done_d = 1'b1;
  end

  always_comb begin
    jam_en_d   = is_jam_state(state_d);
    busy_d     = (state_d != ST_IDLE);
    wr_en_d    = (state_d == ST_DEP_WR);
    wr_data_d  = wr_en_d ? data_d : 8'h00;
    jam_data_d = 8'h00;
    case (state_d)
      ST_EX_JMP:  jam_data_d = OP_JMP;
      ST_EX_LO:   jam_data_d = addr_d[7:0];
      ST_EX_HI:   jam_data_d = addr_d[15:8];
      ST_NXT_NOP: jam_data_d = OP_NOP;
      default:    jam_data_d = 8'h00;
    endcase
  end

  // Switch capture on accept and read-to-read watchdog
  always_comb begin
    addr_d   = accept_c ? addr_sw : addr_q;
    data_d   = accept_c ? data_sw : data_q;
    is_dep_d = accept_c ? (cmd_c == CMD_DEPOSIT_NEXT) : is_dep_q;
    wd_d     = '0;
    if (is_jam_state(state_q) && state_d == state_q && !rd_fall_c) wd_d = wd_q + WD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      data_q     <= '0;
      is_dep_q   <= 1'b0;
      wd_q       <= '0;
      jam_en_q   <= 1'b0;
      jam_data_q <= 8'h00;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      data_q     <= data_d;
      is_dep_q   <= is_dep_d;
      wd_q       <= wd_d;
      jam_en_q   <= jam_en_d;
      jam_data_q <= jam_data_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign jam_en   = jam_en_q;
  assign jam_data = jam_data_q;
  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_front_panel_sequencer.sv
// Self-checking bench for front_panel_sequencer: table-driven operations plus
// hand-written watchdog, reset and abort sequences.
module tb_front_panel_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sw_examine, sw_examine_next, sw_deposit, sw_deposit_next;
  logic        stop_mode, cpu_rd;
  logic [15:0] addr_sw;
  logic [7:0]  data_sw;
  logic        jam_en, wr_en, busy, done, timeout;
  logic [7:0]  jam_data, wr_data;

  front_panel_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .sw_examine      (sw_examine),
    .sw_examine_next (sw_examine_next),
    .sw_deposit      (sw_deposit),
    .sw_deposit_next (sw_deposit_next),
    .stop_mode       (stop_mode),
    .cpu_rd          (cpu_rd),
    .addr_sw         (addr_sw),
    .data_sw         (data_sw),
    .jam_en          (jam_en),
    .jam_data        (jam_data),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .busy            (busy),
    .done            (done),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  // sw bit order: [0] examine, [1] examine_next, [2] deposit, [3] deposit_next
  typedef struct {
    logic [3:0]  sw;
    logic [15:0] addr;
    logic [7:0]  data;
    int          nreads;
    logic [23:0] jam;
    logic        exp_wr;
  } vec_t;

  typedef struct packed {
    logic       done;
    logic       wr;
    logic [7:0] wd;
    logic       to;
  } ev_t;

  vec_t vecs[8];
  ev_t  sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [19:0] outs();
    return {jam_en, jam_data, wr_en, wr_data, busy, done, timeout};
  endfunction

  // Advance one clock and score any done/wr_en/timeout pulse against the queue
  task automatic tick();
    ev_t e;
    @(posedge clk);
    #1;
    if (done || wr_en || timeout) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {29'd0, done, wr_en, timeout}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("event", {21'd0, done, wr_en, wr_data, timeout, jam_en},
              {21'd0, e.done, e.wr, e.wd, e.to, 1'b0});
      end
    end
  endtask

  task automatic issue(input logic [3:0] sw);
    {sw_deposit_next, sw_deposit, sw_examine_next, sw_examine} = sw;
    tick();
    {sw_deposit_next, sw_deposit, sw_examine_next, sw_examine} = 4'b0000;
  endtask

  task automatic do_read(input logic [7:0] exp, input string nm);
    check({nm, "_jam_en"}, {31'd0, jam_en}, 32'd1);
    check({nm, "_jam_data"}, {24'd0, jam_data}, {24'd0, exp});
    cpu_rd = 1'b1;
    repeat (3) tick();
    check({nm, "_jam_hold"}, {24'd0, jam_data}, {24'd0, exp});
    cpu_rd = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0] = '{4'b0001, 16'h1234, 8'h00, 3, 24'hC33412, 1'b0};
    vecs[1] = '{4'b0010, 16'h0000, 8'h00, 1, 24'h000000, 1'b0};
    vecs[2] = '{4'b1000, 16'h0000, 8'hA5, 1, 24'h000000, 1'b1};
    vecs[3] = '{4'b0100, 16'h0000, 8'h3C, 0, 24'h000000, 1'b1};
    vecs[4] = '{4'b0101, 16'hABCD, 8'h77, 3, 24'hC3CDAB, 1'b0};
    vecs[5] = '{4'b1010, 16'h0000, 8'h11, 1, 24'h000000, 1'b0};
    vecs[6] = '{4'b1100, 16'h0000, 8'h5A, 1, 24'h000000, 1'b1};
    vecs[7] = '{4'b0001, 16'hFFFF, 8'h00, 3, 24'hC3FFFF, 1'b0};

    reset = 1'b1;
    stop_mode = 1'b1;
    cpu_rd = 1'b0;
    addr_sw = '0;
    data_sw = '0;
    {sw_deposit_next, sw_deposit, sw_examine_next, sw_examine} = 4'b0000;
    repeat (3) tick();
    check("reset_outs", {12'd0, outs()}, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_outs", {12'd0, outs()}, 32'd0);

    for (int v = 0; v < 8; v++) begin
      addr_sw = vecs[v].addr;
      data_sw = vecs[v].data;
      if (vecs[v].nreads == 0) sb.push_back('{1'b1, 1'b1, vecs[v].data, 1'b0});
      issue(vecs[v].sw);
      check($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd1);
      addr_sw = ~vecs[v].addr;
      data_sw = ~vecs[v].data;
      for (int k = 0; k < vecs[v].nreads; k++) begin
        if (k == vecs[v].nreads - 1)
          sb.push_back('{1'b1, vecs[v].exp_wr, vecs[v].exp_wr ? vecs[v].data : 8'h00, 1'b0});
        do_read(vecs[v].jam[23-8*k -: 8], $sformatf("vec%0d_rd%0d", v, k));
      end
      tick();
      tick();
      check($sformatf("vec%0d_idle", v), {12'd0, outs()}, 32'd0);
      check($sformatf("vec%0d_sb_empty", v), sb.size(), 32'd0);
    end

    // Deposit edge while an examine is running must be dropped
    addr_sw = 16'h0042;
    issue(4'b0001);
    do_read(8'hC3, "busy_rd0");
    sw_deposit = 1'b1;
    do_read(8'h42, "busy_rd1");
    sb.push_back('{1'b1, 1'b0, 8'h00, 1'b0});
    do_read(8'h00, "busy_rd2");
    repeat (3) tick();
    sw_deposit = 1'b0;
    tick();
    check("busy_edge_idle", {12'd0, outs()}, 32'd0);

    // Watchdog: no reads after examine starts
    addr_sw = 16'h0000;
    sb.push_back('{1'b0, 1'b0, 8'h00, 1'b1});
    issue(4'b0001);
    begin
      int k;
      k = 0;
      while (!timeout && k < 40) begin
        tick();
        k++;
      end
      check("timeout_latency", k, 32'd17);
    end
    check("timeout_outs", {12'd0, outs()}, 32'd1);
    tick();
    check("after_timeout", {12'd0, outs()}, 32'd0);

    // Reset while in EX_LO
    addr_sw = 16'hBEEF;
    issue(4'b0001);
    do_read(8'hC3, "rst_rd0");
    check("rst_exlo_jam", {24'd0, jam_data}, 32'hEF);
    reset = 1'b1;
    tick();
    check("rst_mid_outs", {12'd0, outs()}, 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    check("rst_after_outs", {12'd0, outs()}, 32'd0);

    // stop_mode drop while in EX_HI
    addr_sw = 16'h5678;
    issue(4'b0001);
    do_read(8'hC3, "stop_rd0");
    do_read(8'h78, "stop_rd1");
    check("stop_exhi_jam", {24'd0, jam_data}, 32'h56);
    stop_mode = 1'b0;
    tick();
    check("stop_abort_outs", {12'd0, outs()}, 32'd0);
    stop_mode = 1'b1;
    tick();
    check("stop_after_outs", {12'd0, outs()}, 32'd0);

    // Read completion coincident with stop_mode drop: abort wins, no done
    addr_sw = 16'h9ABC;
    issue(4'b0001);
    do_read(8'hC3, "coin_rd0");
    do_read(8'hBC, "coin_rd1");
    cpu_rd = 1'b1;
    repeat (2) tick();
    cpu_rd = 1'b0;
    stop_mode = 1'b0;
    tick();
    check("coin_abort_outs", {12'd0, outs()}, 32'd0);
    stop_mode = 1'b1;
    repeat (2) tick();
    check("coin_after_outs", {12'd0, outs()}, 32'd0);

    // Edge while the CPU is running is discarded
    stop_mode = 1'b0;
    data_sw = 8'h99;
    issue(4'b0100);
    check("run_edge_ignored", {12'd0, outs()}, 32'd0);
    stop_mode = 1'b1;
    repeat (2) tick();
    check("run_edge_after", {12'd0, outs()}, 32'd0);

    check("sb_final_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
